// File: rtl/exmem_skid.sv
// exmem_skid: EX/MEM pipeline register with a two-entry skid buffer.
// Holds up to two EX bundles in FIFO order. The head register drives the MEM
// side and a skid register absorbs one extra bundle. That extra entry lets
// in_ready_o be a pure register, with no combinational path from out_ready_i.
// The memory address is computed on capture, so the MEM stage sees it ready.
// Optional feature: define EXMEM_MISALIGN_CHK_EN to add out_misalign_o. It is
// a registered flag for memory accesses whose address is not word-aligned.
module exmem_skid #(
    parameter int XLEN = 32,
    parameter int RAW  = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic            flush_i,
    input  logic            wb_i,
    input  logic [1:0]      mem_i,
    input  logic [XLEN-1:0] alu_res_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [RAW-1:0]  rd_addr_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic            out_wb_o,
    output logic [1:0]      out_mem_o,
    output logic [XLEN-1:0] out_memaddr_o,
    output logic [XLEN-1:0] out_memdata_o,
    output logic [XLEN-1:0] out_alures_o,
    output logic [RAW-1:0]  out_rd_addr_o,
`ifdef EXMEM_MISALIGN_CHK_EN
    output logic            out_misalign_o,
`endif
    output logic [1:0]      count_o
);

    typedef struct packed {
        logic            wb;
        logic [1:0]      mem;
        logic [XLEN-1:0] memaddr;
        logic [XLEN-1:0] memdata;
        logic [XLEN-1:0] alures;
        logic [RAW-1:0]  rd_addr;
`ifdef EXMEM_MISALIGN_CHK_EN
        logic            misalign;
`endif
    } bundle_t;

    bundle_t    head_q, head_d;
    bundle_t    skid_q, skid_d;
    bundle_t    new_b;
    logic [1:0] count_q, count_d;
    logic       in_ready_q, in_ready_d;
    logic       acc, ret;
    logic [XLEN-1:0] addr;

    // Form the incoming bundle; mem==01 uses register+register addressing.
    always_comb begin
        addr          = (mem_i == 2'b01) ? (rs1_data_i + rs2_data_i)
                                         : (rs1_data_i + imm_i);
        new_b         = '0;
        new_b.wb      = wb_i;
        new_b.mem     = mem_i;
        new_b.memaddr = addr;
        new_b.memdata = rs2_data_i;
        new_b.alures  = alu_res_i;
        new_b.rd_addr = rd_addr_i;
`ifdef EXMEM_MISALIGN_CHK_EN
        new_b.misalign = (mem_i != 2'b00) && (addr[1:0] != 2'b00);
`endif
    end

    assign acc = in_valid_i && in_ready_q && !flush_i;
    assign ret = (count_q != 2'd0) && out_ready_i;

    // Next-state for occupancy and the two entries. Flush only clears the
    // occupancy; stale payload is left in place and hidden by out_valid_o=0.
    always_comb begin
        head_d  = head_q;
        skid_d  = skid_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (acc) begin
                        head_d  = new_b;
                        count_d = 2'd1;
                    end
                end
                2'd1: begin
                    if (acc && ret) begin
                        head_d = new_b;
                    end else if (acc) begin
                        skid_d  = new_b;
                        count_d = 2'd2;
                    end else if (ret) begin
                        count_d = 2'd0;
                    end
                end
                default: begin
                    // Full: in_ready is low, so only a retire can happen.
                    if (ret) begin
                        head_d  = skid_q;
                        count_d = 2'd1;
                    end
                end
            endcase
        end
        in_ready_d = (count_d != 2'd2);
    end

    // State registers; reset clears occupancy and zeroes payload.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q     <= '0;
            skid_q     <= '0;
            count_q    <= 2'd0;
            in_ready_q <= 1'b1;
        end else begin
            head_q     <= head_d;
            skid_q     <= skid_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready_o    = in_ready_q;
    assign out_valid_o   = (count_q != 2'd0);
    assign count_o       = count_q;
    assign out_wb_o      = head_q.wb;
    assign out_mem_o     = head_q.mem;
    assign out_memaddr_o = head_q.memaddr;
    assign out_memdata_o = head_q.memdata;
    assign out_alures_o  = head_q.alures;
    assign out_rd_addr_o = head_q.rd_addr;
`ifdef EXMEM_MISALIGN_CHK_EN
    assign out_misalign_o = head_q.misalign;
`endif

endmodule

// File: tb/tb_exmem_skid.sv
// Testbench for exmem_skid: directed scenarios plus a randomized phase.
// Expected bundles are queued on acceptance and compared on retirement.
module tb_exmem_skid;

    localparam int XLEN = 32;
    localparam int RAW  = 5;

    logic            clk = 1'b0;
    logic            rst, in_valid, flush, wb, out_ready;
    logic [1:0]      mem;
    logic [XLEN-1:0] alu_res, imm, rs1, rs2;
    logic [RAW-1:0]  rd;
    logic            in_ready_o, out_valid_o, out_wb_o;
    logic [1:0]      out_mem_o, count_o;
    logic [XLEN-1:0] out_memaddr_o, out_memdata_o, out_alures_o;
    logic [RAW-1:0]  out_rd_addr_o;
`ifdef EXMEM_MISALIGN_CHK_EN
    logic            out_misalign_o;
`endif

    typedef struct {
        logic            wb;
        logic [1:0]      mem;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] alu;
        logic [RAW-1:0]  rd;
        logic            mis;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en   = 1'b0;

    exmem_skid #(.XLEN(XLEN), .RAW(RAW)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_o),
        .flush_i(flush), .wb_i(wb), .mem_i(mem), .alu_res_i(alu_res), .imm_i(imm),
        .rs1_data_i(rs1), .rs2_data_i(rs2), .rd_addr_i(rd),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready),
        .out_wb_o(out_wb_o), .out_mem_o(out_mem_o), .out_memaddr_o(out_memaddr_o),
        .out_memdata_o(out_memdata_o), .out_alures_o(out_alures_o),
        .out_rd_addr_o(out_rd_addr_o),
`ifdef EXMEM_MISALIGN_CHK_EN
        .out_misalign_o(out_misalign_o),
`endif
        .count_o(count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Independent reference: address and misalign computed from the driven inputs.
    function automatic exp_t model();
        exp_t e;
        e.wb   = wb;
        e.mem  = mem;
        e.addr = (mem == 2'b01) ? rs1 + rs2 : rs1 + imm;
        e.data = rs2;
        e.alu  = alu_res;
        e.rd   = rd;
        e.mis  = (mem != 2'b00) && (e.addr[1:0] != 2'b00);
        return e;
    endfunction

    // Scoreboard monitor: compares outputs to the model queue, then applies this cycle's inputs.
    always @(negedge clk) begin
        if (mon_en) begin
            int  sz;
            bit  acc, ret;
            sz = q.size();
            chk("count", 64'(count_o), 64'(sz));
            chk("out_valid", 64'(out_valid_o), 64'(sz != 0));
            chk("in_ready", 64'(in_ready_o), 64'(sz < 2));
            if (sz != 0) begin
                chk("head_wb", 64'(out_wb_o), 64'(q[0].wb));
                chk("head_mem", 64'(out_mem_o), 64'(q[0].mem));
                chk("head_addr", 64'(out_memaddr_o), 64'(q[0].addr));
                chk("head_data", 64'(out_memdata_o), 64'(q[0].data));
                chk("head_alu", 64'(out_alures_o), 64'(q[0].alu));
                chk("head_rd", 64'(out_rd_addr_o), 64'(q[0].rd));
`ifdef EXMEM_MISALIGN_CHK_EN
                chk("head_mis", 64'(out_misalign_o), 64'(q[0].mis));
`endif
            end
            acc = in_valid && (sz < 2);
            ret = (sz != 0) && out_ready;
            if (rst || flush) begin
                q.delete();
            end else begin
                if (ret) void'(q.pop_front());
                if (acc) q.push_back(model());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_b(input logic [1:0] m, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] i, input logic [XLEN-1:0] alu);
        in_valid = 1'b1;
        mem      = m;
        rs1      = a;
        rs2      = b;
        imm      = i;
        alu_res  = alu;
        wb       = alu[4];
        rd       = alu[RAW-1:0];
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_count"}, 64'(count_o), 64'd0);
        chk({tag, "_valid"}, 64'(out_valid_o), 64'd0);
        chk({tag, "_ready"}, 64'(in_ready_o), 64'd1);
        chk({tag, "_payload"}, 64'({out_wb_o, out_mem_o, out_rd_addr_o}), 64'd0);
        chk({tag, "_addr"}, 64'(out_memaddr_o), 64'd0);
        chk({tag, "_data"}, 64'(out_memdata_o), 64'd0);
        chk({tag, "_alu"}, 64'(out_alures_o), 64'd0);
`ifdef EXMEM_MISALIGN_CHK_EN
        chk({tag, "_mis"}, 64'(out_misalign_o), 64'd0);
`endif
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        wb = 1'b0; mem = 2'b00; alu_res = '0; imm = '0; rs1 = '0; rs2 = '0; rd = '0;
        step();
        mon_en = 1'b1;
        step();
        rst = 1'b0;
        chk_zero_outputs("reset");

        // Basic capture with 1-cycle latency, rs1+imm addressing.
        out_ready = 1'b1;
        set_b(2'b10, 32'h100, 32'h55, 32'h24, 32'h0A);
        step();
        in_valid = 1'b0;
        chk("lat_valid", 64'(out_valid_o), 64'd1);
        chk("lat_addr", 64'(out_memaddr_o), 64'h124);
        chk("lat_count", 64'(count_o), 64'd1);
        step();

        // rs1+rs2 addressing wraps modulo 2^XLEN.
        set_b(2'b01, 32'hFFFF_FFFF, 32'h2, 32'h7777, 32'h11);
        step();
        in_valid = 1'b0;
        chk("wrap_addr", 64'(out_memaddr_o), 64'h1);
        chk("wrap_data", 64'(out_memdata_o), 64'h2);
        step();

        // Backpressure: A,B fill the buffer, C is held off, then all drain in order.
        out_ready = 1'b0;
        set_b(2'b10, 32'h200, 32'h1, 32'h4, 32'hA0);
        step();
        set_b(2'b11, 32'h300, 32'h2, 32'h8, 32'hB0);
        step();
        chk("bp_count2", 64'(count_o), 64'd2);
        chk("bp_ready0", 64'(in_ready_o), 64'd0);
        set_b(2'b01, 32'h400, 32'h3, 32'hC, 32'hC0);
        step();
        step();
        chk("bp_hold_count", 64'(count_o), 64'd2);
        chk("bp_hold_alu", 64'(out_alures_o), 64'hA0);
        out_ready = 1'b1;
        step();
        chk("bp_order_B", 64'(out_alures_o), 64'hB0);
        step();
        in_valid = 1'b0;
        chk("bp_order_C", 64'(out_alures_o), 64'hC0);
        step();
        chk("bp_empty", 64'(count_o), 64'd0);

        // Flush while full with a valid input present.
        out_ready = 1'b0;
        set_b(2'b10, 32'h500, 32'h0, 32'h0, 32'hD1);
        step();
        set_b(2'b10, 32'h600, 32'h0, 32'h0, 32'hD2);
        step();
        set_b(2'b10, 32'h700, 32'h0, 32'h0, 32'hD3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_count", 64'(count_o), 64'd0);
        chk("fl_valid", 64'(out_valid_o), 64'd0);
        chk("fl_ready", 64'(in_ready_o), 64'd1);
        out_ready = 1'b1;
        repeat (3) step();

        // Reset while full.
        out_ready = 1'b0;
        set_b(2'b11, 32'h800, 32'h9, 32'h1, 32'hE1);
        step();
        set_b(2'b11, 32'h900, 32'h9, 32'h1, 32'hE2);
        step();
        chk("rs_full", 64'(count_o), 64'd2);
        rst = 1'b1;
        out_ready = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        chk_zero_outputs("midrst");

`ifdef EXMEM_MISALIGN_CHK_EN
        set_b(2'b10, 32'h100, 32'h0, 32'h2, 32'h31);
        step();
        chk("mis_set", 64'(out_misalign_o), 64'd1);
        set_b(2'b00, 32'h100, 32'h0, 32'h2, 32'h32);
        step();
        in_valid = 1'b0;
        chk("mis_clr", 64'(out_misalign_o), 64'd0);
        step();
`endif

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 15) == 0);
            mem       = 2'($urandom_range(0, 3));
            rs1       = $urandom;
            rs2       = $urandom;
            imm       = $urandom;
            alu_res   = $urandom;
            wb        = 1'($urandom_range(0, 1));
            rd        = RAW'($urandom_range(0, 31));
            step();
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        mon_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/exmem_skid.md
EXMEM_SKID -- requirements
Module: exmem_skid

Interface
REQ-001 SHALL provide parameter XLEN, default 32, data/address width.
REQ-002 SHALL provide parameter RAW, default 5, destination register address width.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid_i, input, 1, the EX stage presents a bundle.
REQ-006 SHALL have port in_ready_o, input side, output, 1, block can accept a bundle.
REQ-007 SHALL have port flush_i, input, 1, discard all held and incoming bundles.
REQ-008 SHALL have inputs wb_i (1), mem_i (2), alu_res_i (XLEN), imm_i (XLEN), rs1_data_i (XLEN), rs2_data_i (XLEN) and rd_addr_i (RAW), together forming the EX bundle.
REQ-009 SHALL have port out_valid_o, output, 1, the head bundle is valid.
REQ-010 SHALL have port out_ready_i, input, 1, the MEM stage consumes the head bundle.
REQ-011 SHALL have outputs out_wb_o (1), out_mem_o (2), out_memaddr_o (XLEN), out_memdata_o (XLEN), out_alures_o (XLEN) and out_rd_addr_o (RAW), together forming the head bundle.
REQ-012 SHALL have port count_o, output, 2, number of held bundles (0..2).

Function
REQ-013 SHALL hold up to 2 bundles in FIFO order: a head register driving the outputs and a skid register.
REQ-014 SHALL accept a bundle on an edge where in_valid_i=1, in_ready_o=1 and flush_i=0.
REQ-015 SHALL retire the head on an edge where out_valid_o=1 and out_ready_i=1.
REQ-016 SHALL drive in_ready_o as a registered signal equal to (count<2); no combinational path from out_ready_i to in_ready_o.
REQ-017 SHALL compute the captured memaddr as rs1_data_i+rs2_data_i when mem_i==2'b01, else rs1_data_i+imm_i, modulo 2^XLEN (carry discarded).
REQ-018 SHALL capture memdata=rs2_data_i and pass alures, wb, mem and rd_addr unchanged.
REQ-019 SHALL present an accepted bundle on the outputs the next cycle when empty, giving 1-cycle latency.
REQ-020 SHALL, with count=1 and simultaneous accept and retire, load the new bundle directly into the head, leaving count at 1.
REQ-021 SHALL, with count=1 and accept without retire, place the new bundle in skid, giving count 2.
REQ-022 SHALL, with count=2 and retire, move skid to head, giving count 1; no accept occurs because in_ready_o=0.
REQ-023 SHALL, when flush_i=1, set count to 0 and out_valid_o to 0 next cycle, drop any same-cycle input, and return in_ready_o to 1.
REQ-024 SHALL keep output payload stable while out_valid_o=1 and out_ready_i=0.
REQ-025 SHALL hold the last payload when out_valid_o=0; the payload is don't-care but contains no X after reset.

Reset
REQ-026 SHALL on rst_i=1 set count_o=0, out_valid_o=0, in_ready_o=1, and zero all payload outputs and out_misalign_o.
REQ-027 SHALL make reset override flush, accept and retire, discarding all held bundles mid-operation.

Configuration
REQ-028 SHALL, with macro EXMEM_MISALIGN_CHK_EN defined, add output out_misalign_o (1), registered with the bundle, =1 when mem!=2'b00 and memaddr[1:0]!=2'b00.
REQ-029 SHALL, without EXMEM_MISALIGN_CHK_EN, omit out_misalign_o, leaving all other behaviour identical.

Verification
REQ-030 SHALL cover: reset, then mem_i=2'b10, rs1=0x100, imm=0x24, out_ready=1 -> next cycle out_valid=1, memaddr=0x124, count=1.
REQ-031 SHALL cover: mem_i=2'b01, rs1=0xFFFFFFFF, rs2=0x2 -> memaddr=0x00000001 (wrap), memdata=0x2.
REQ-032 SHALL cover: out_ready=0 with 3 back-to-back valid bundles -> count=2, in_ready=0 after the 2nd, 3rd held off; then out_ready=1 -> bundles emerge in order A,B,C.
REQ-033 SHALL cover: count=2, flush_i=1 with in_valid=1 -> next cycle count=0, out_valid=0, in_ready=1, and the input bundle is never emitted.
REQ-034 SHALL cover: rst_i=1 asserted while count=2 -> next cycle count=0 and all outputs zero.
REQ-035 SHALL cover, with EXMEM_MISALIGN_CHK_EN: mem_i=2'b10, rs1=0x100, imm=0x2 -> out_misalign_o=1; mem_i=2'b00 with the same address -> out_misalign_o=0.
